// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg: shared defaults, instruction field layout and the
// write-source encoding used by the data-memory arbiter.
package data_mem_arb_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 8;
    localparam int WB_DELAY_DEF = 4;
    localparam int TX_BASE_DEF  = 'h8F;

    // Instruction word is {src2, src1, dst}; each field is ADDR_W bits wide.
    localparam int DST_FIELD  = 0;
    localparam int SRC1_FIELD = 1;
    localparam int SRC2_FIELD = 2;

    // Bit offset of a field inside the instruction word.
    function automatic int field_lsb(input int field, input int addr_w);
        return field * addr_w;
    endfunction

    typedef enum logic [1:0] {
        WR_NONE = 2'd0,
        WR_LOAD = 2'd1,
        WR_WB   = 2'd2,
        WR_TX   = 2'd3
    } wr_sel_e;

endpackage

// File: rtl/data_mem_arb_sdp_bram.sv
// sdp_bram: simple dual-port RAM (one write port, one read port).
// HIGH_PERF=1 adds an output register, giving a 2-cycle read latency;
// the output holds its value when no read is in flight. Read-during-write
// to the same address returns the old word.
module sdp_bram
    import data_mem_arb_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter bit HIGH_PERF = 1'b1
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_p1_q;

    // Write port; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    // First read stage: array read register.
    always_ff @(posedge clk_i) begin
        if (re_i) rd_p1_q <= mem[raddr_i];
    end

    if (HIGH_PERF) begin : g_outreg
        logic              re_p1_q;
        logic [DATA_W-1:0] rdata_q;

        // Second read stage: output register, cleared by reset.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                re_p1_q <= 1'b0;
                rdata_q <= '0;
            end else begin
                re_p1_q <= re_i;
                if (re_p1_q) rdata_q <= rd_p1_q;
            end
        end

        assign rdata_o = rdata_q;
    end else begin : g_noreg
        assign rdata_o = rd_p1_q;
    end

endmodule

// File: rtl/data_mem_arb.sv
// data_mem_arb: dual-bank data memory with load / write-back / transfer
// write arbitration (fixed priority load > write-back > transfer).
// Bank A is read at src1, bank B at src2; both banks receive every write.
// Macro DATA_MEM_ARB_BYPASS_EN: defined -> write-first reads through a
// 2-stage forwarding path; undefined -> read-first, no forwarding logic.
module data_mem_arb
    import data_mem_arb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int WB_DELAY = WB_DELAY_DEF,
    parameter int TX_BASE  = TX_BASE_DEF
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_v,
    input  logic [DATA_W-1:0]     ld_data,
    input  logic                  tx_v,
    input  logic [DATA_W-1:0]     tx_data,
    output logic                  tx_rdy,
    input  logic                  wb_v,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  inst_v,
    input  logic [3*ADDR_W-1:0]   inst,
    input  logic                  rden,
    output logic [DATA_W-1:0]     douta,
    output logic [DATA_W-1:0]     doutb,
    output logic                  dout_v,
    output logic                  tx_ovf
);

    localparam int SRC1_LSB = field_lsb(SRC1_FIELD, ADDR_W);
    localparam int SRC2_LSB = field_lsb(SRC2_FIELD, ADDR_W);
    localparam int DST_LSB  = field_lsb(DST_FIELD, ADDR_W);

    // Instruction decode; an instruction coinciding with a load is dropped.
    logic              inst_acc;
    logic [ADDR_W-1:0] src1, src2, dst;
    assign inst_acc = inst_v & ~ld_v;
    assign src1     = inst[SRC1_LSB +: ADDR_W];
    assign src2     = inst[SRC2_LSB +: ADDR_W];
    assign dst      = inst[DST_LSB  +: ADDR_W];

    logic [ADDR_W-1:0] ra1_q, ra2_q;
    logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
    logic [ADDR_W-1:0] dpipe_q [WB_DELAY];
    logic              wb_v_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [ADDR_W-1:0] ld_ptr_q, tx_ptr_q;
    logic              pend_q, rdy_en_q, ovf_q;
    logic [DATA_W-1:0] pend_data_q;
    logic              rv_p1_q, rv_p2_q;
    logic              tx_acc;
    wr_sel_e           wsel;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] bank_a_rd, bank_b_rd;

    // A read issued together with an accepted instruction uses the new
    // source fields directly; otherwise the latched read addresses.
    assign rd_addr_a = inst_acc ? src1 : ra1_q;
    assign rd_addr_b = inst_acc ? src2 : ra2_q;

    // Read-address registers, loaded by each accepted instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra1_q <= '0;
            ra2_q <= '0;
        end else if (inst_acc) begin
            ra1_q <= src1;
            ra2_q <= src2;
        end
    end

    // Destination delay line: shifts every cycle, zero when no instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WB_DELAY; i++) dpipe_q[i] <= '0;
        end else begin
            dpipe_q[0] <= inst_acc ? dst : '0;
            for (int i = 1; i < WB_DELAY; i++) dpipe_q[i] <= dpipe_q[i-1];
        end
    end

    // Write-back strobe registered one cycle; reset discards it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wb_v_q <= 1'b0;
        else     wb_v_q <= wb_v;
    end

    // Write-back word and its destination, captured alongside the strobe.
    always_ff @(posedge clk) begin
        wb_data_q <= wb_data;
        wb_addr_q <= dpipe_q[WB_DELAY-1];
    end

    // One write per cycle: load beats write-back beats pending transfer.
    always_comb begin
        wsel    = WR_NONE;
        wr_addr = '0;
        wr_data = '0;
        if (ld_v) begin
            wsel    = WR_LOAD;
            wr_addr = ld_ptr_q;
            wr_data = ld_data;
        end else if (wb_v_q) begin
            wsel    = WR_WB;
            wr_addr = wb_addr_q;
            wr_data = wb_data_q;
        end else if (pend_q) begin
            wsel    = WR_TX;
            wr_addr = tx_ptr_q;
            wr_data = pend_data_q;
        end
    end

    assign wr_en  = (wsel != WR_NONE);
    assign tx_rdy = rdy_en_q & ~pend_q;
    assign tx_acc = tx_v & tx_rdy;
    assign tx_ovf = ovf_q;

    // Pointers, pending-transfer slot and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_ptr_q <= '0;
            tx_ptr_q <= ADDR_W'(TX_BASE);
            pend_q   <= 1'b0;
            rdy_en_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (wsel == WR_LOAD) ld_ptr_q <= ld_ptr_q + ADDR_W'(1);
            if (wsel == WR_TX) begin
                tx_ptr_q <= tx_ptr_q + ADDR_W'(1);
                pend_q   <= 1'b0;
            end
            if (tx_acc) pend_q <= 1'b1;
            if (tx_v && !tx_rdy) ovf_q <= 1'b1;
        end
    end

    // Pending transfer word.
    always_ff @(posedge clk) begin
        if (tx_acc) pend_data_q <= tx_data;
    end

    // Read-valid pipeline matching the two bank read stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_p1_q <= 1'b0;
            rv_p2_q <= 1'b0;
        end else begin
            rv_p1_q <= rden;
            rv_p2_q <= rv_p1_q;
        end
    end

    assign dout_v = rv_p2_q;

    sdp_bram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HIGH_PERF(1'b1)) u_bank_a (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .re_i    (rden),
        .raddr_i (rd_addr_a),
        .rdata_o (bank_a_rd)
    );

    sdp_bram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HIGH_PERF(1'b1)) u_bank_b (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .re_i    (rden),
        .raddr_i (rd_addr_b),
        .rdata_o (bank_b_rd)
    );

`ifdef DATA_MEM_ARB_BYPASS_EN
    logic              hit_a_p1_q, hit_b_p1_q, hit_a_p2_q, hit_b_p2_q;
    logic [DATA_W-1:0] fwd_p1_q, fwd_p2_q;

    // Forwarding hit flags follow the read through both stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_a_p1_q <= 1'b0;
            hit_b_p1_q <= 1'b0;
            hit_a_p2_q <= 1'b0;
            hit_b_p2_q <= 1'b0;
        end else begin
            if (rden) begin
                hit_a_p1_q <= wr_en && (wr_addr == rd_addr_a);
                hit_b_p1_q <= wr_en && (wr_addr == rd_addr_b);
            end
            if (rv_p1_q) begin
                hit_a_p2_q <= hit_a_p1_q;
                hit_b_p2_q <= hit_b_p1_q;
            end
        end
    end

    // Forwarded write word, advanced in step with the hit flags.
    always_ff @(posedge clk) begin
        if (rden)    fwd_p1_q <= wr_data;
        if (rv_p1_q) fwd_p2_q <= fwd_p1_q;
    end

    assign douta = hit_a_p2_q ? fwd_p2_q : bank_a_rd;
    assign doutb = hit_b_p2_q ? fwd_p2_q : bank_b_rd;
`else
    assign douta = bank_a_rd;
    assign doutb = bank_b_rd;
`endif

endmodule
